// File: rtl/regfile_mp_if.sv
// Register-file access bundle: write port, two read ports, clear control and pending-bit scoreboard.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWr;
  logic [ADDR_W-1:0] Rw;
  logic [DATA_W-1:0] Di;
  logic [ADDR_W-1:0] Ra;
  logic [DATA_W-1:0] busA;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] busB;
  logic              Clear;
  logic              Busy;
  logic              SetPend;
  logic [ADDR_W-1:0] PendAddr;
  logic              PendA;
  logic              PendB;

  modport master (
    output RegWr, Rw, Di, Ra, Rb, Clear, SetPend, PendAddr,
    input  busA, busB, Busy, PendA, PendB
  );

  modport slave (
    input  RegWr, Rw, Di, Ra, Rb, Clear, SetPend, PendAddr,
    output busA, busB, Busy, PendA, PendB
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with write bypass, per-entry pending bits and a
// sequenced clear that sweeps every entry to zero after reset or on request.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic         CLK,
  input logic         Reset,
  regfile_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend_q;

  logic busy, wr_en, set_en, enter_clear;
  logic zero_a, zero_b;

  assign busy        = (state_q == CLEAR);
  assign wr_en       = !busy && bus.RegWr   && !(ZERO_REG && (bus.Rw == '0));
  assign set_en      = !busy && bus.SetPend && !(ZERO_REG && (bus.PendAddr == '0));
  assign enter_clear = !busy && bus.Clear;
  assign zero_a      = busy || (ZERO_REG && (bus.Ra == '0));
  assign zero_b      = busy || (ZERO_REG && (bus.Rb == '0));

  // State and clear-counter register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: Clear only honoured from IDLE; sweep ends after the last entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.Clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; the sweep is the only way entries are zeroed
  always_ff @(posedge CLK) begin
    if (busy)       mem[cnt_q]  <= '0;
    else if (wr_en) mem[bus.Rw] <= bus.Di;
  end

  // Pending bits: a new producer (set) overrides a same-cycle retire (write)
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pend_q <= '0;
    end else if (enter_clear) begin
      pend_q <= '0;
    end else begin
      if (wr_en)  pend_q[bus.Rw]       <= 1'b0;
      if (set_en) pend_q[bus.PendAddr] <= 1'b1;
    end
  end

  assign bus.Busy  = busy;
  assign bus.busA  = zero_a ? '0 : ((wr_en && (bus.Rw == bus.Ra)) ? bus.Di : mem[bus.Ra]);
  assign bus.busB  = zero_b ? '0 : ((wr_en && (bus.Rw == bus.Rb)) ? bus.Di : mem[bus.Rb]);
  assign bus.PendA = !zero_a && pend_q[bus.Ra];
  assign bus.PendB = !zero_b && pend_q[bus.Rb];
endmodule
